// File: rtl/capture_pkg.sv
// Shared definitions for the sample-capture buffer: FSM state encoding and
// default geometry.
package capture_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        FULL    = 3'd3,
        READ    = 3'd4
    } state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one synchronous write port, one synchronous
// read port with a registered output. The array itself is never reset; only
// the output register is, so readout presents zero after reset.
module capture_ram
    import capture_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port: store a sample when enabled.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read port: registered output that holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/capture_buffer.sv
// Capture buffer: after arm + trigger, records DEPTH valid samples into a
// RAM, then plays them back one word per accepted rd_en with one cycle of
// latency. rd_valid/rd_last are pipelined to line up with the RAM output.
module capture_buffer
    import capture_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     trig,
    input  logic                     din_valid,
    input  logic [DATA_W-1:0]        din,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     rd_last,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;

    // State, address counters, sample count and read-qualifier pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    // Next-state logic plus RAM write/read strobes.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        count_d    = count_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_raddr  = rd_addr_q;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d   = ARMED;
                    count_d   = '0;
                    wr_addr_d = '0;
                end
            end
            ARMED: begin
                // wr_addr_q is zero here, so the first sample lands at 0.
                if (trig && din_valid) begin
                    ram_we    = 1'b1;
                    wr_addr_d = wr_addr_q + ADDR_ONE;
                    count_d   = CNT_ONE;
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (din_valid) begin
                    ram_we    = 1'b1;
                    wr_addr_d = wr_addr_q + ADDR_ONE;
                    count_d   = count_q + CNT_ONE;
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                // A read request takes priority over re-arming.
                if (rd_en) begin
                    ram_re     = 1'b1;
                    ram_raddr  = '0;
                    rd_addr_d  = ADDR_ONE;
                    rd_valid_d = 1'b1;
                    state_d    = READ;
                end else if (arm) begin
                    state_d   = ARMED;
                    count_d   = '0;
                    wr_addr_d = '0;
                end
            end
            READ: begin
                if (rd_en) begin
                    ram_re     = 1'b1;
                    rd_addr_d  = rd_addr_q + ADDR_ONE;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (rd_addr_q == LAST_ADDR);
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (ram_we),
        .waddr_i (wr_addr_q),
        .wdata_i (din),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (rd_data)
    );

    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign busy     = (state_q == ARMED) || (state_q == CAPTURE) || (state_q == READ);
    assign done     = (state_q == FULL);
    assign count    = count_q;

endmodule

// File: tb/tb_capture_buffer.sv
// Bench for capture_buffer: randomized capture/readout sequences checked
// against a queue-based model of the samples that should be stored.
module tb_capture_buffer;

    localparam int DW = 4;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0;
    logic          trig = 1'b0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic          busy;
    logic          done;
    logic [4:0]    count;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_rd_data = '0;

    capture_buffer #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .trig      (trig),
        .din_valid (din_valid),
        .din       (din),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arm, optionally present trig without valid, then feed samples until
    // the model says DEPTH samples are stored. vmode: 0 always valid,
    // 1 alternate, 2 random. dmode: 0 ramp, 1 random, 2 first=7 then random.
    task automatic capture(input int vmode, input int dmode, input int pre_idle);
        int cyc;
        bit v;
        logic [DW-1:0] d;
        arm = 1'b1; trig = 1'b0; din_valid = 1'b0; rd_en = 1'b0;
        tick();
        check("arm_busy", busy, 1);
        check("arm_count", count, 0);
        check("arm_done", done, 0);
        // repeated arm while armed has no effect
        tick();
        arm = 1'b0;
        check("rearm_count", count, 0);
        check("rearm_busy", busy, 1);
        for (int i = 0; i < pre_idle; i++) begin
            trig = 1'b1; din_valid = 1'b0; din = DW'($urandom);
            tick();
            check("trig_novalid_count", count, 0);
            check("trig_novalid_busy", busy, 1);
        end
        exp_q.delete();
        cyc = 0;
        while (exp_q.size() < DP && cyc < 200) begin
            if (cyc == 0)       v = 1'b1;
            else if (vmode == 0) v = 1'b1;
            else if (vmode == 1) v = (cyc % 2 == 0);
            else                 v = 1'($urandom_range(0, 1));
            if (dmode == 0)                   d = DW'(exp_q.size());
            else if (dmode == 2 && cyc == 0)  d = DW'(7);
            else                              d = DW'($urandom);
            trig = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            arm  = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            din_valid = v; din = d;
            tick();
            cyc++;
            if (v) exp_q.push_back(d);
            check("cap_count", count, exp_q.size());
            check("cap_done", done, (exp_q.size() == DP));
            check("cap_busy", busy, (exp_q.size() < DP));
        end
        arm = 1'b0; trig = 1'b0;
        if (cyc >= 200) check("cap_cycle_budget", cyc, 0);
        if (vmode == 0) check("cap_cycles_full", cyc, 16);
        if (vmode == 1) check("cap_cycles_alt", cyc, 31);
        // extra samples after FULL must be dropped
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b1; din = DW'($urandom);
            tick();
            check("full_count", count, DP);
            check("full_done", done, 1);
        end
        din_valid = 1'b0;
    endtask

    // Read the captured block back. rmode: 0 continuous, 1 every third
    // cycle, 2 random. with_arm: assert arm together with the first rd_en.
    task automatic readout(input int rmode, input bit with_arm);
        int idx;
        int cyc;
        bit r;
        idx = 0;
        cyc = 0;
        while (idx < DP && cyc < 300) begin
            if (rmode == 0)      r = 1'b1;
            else if (rmode == 1) r = (cyc % 3 == 0);
            else                 r = 1'($urandom_range(0, 1));
            if (cyc == 0 && with_arm) r = 1'b1;
            arm = (cyc == 0 && with_arm) ? 1'b1 : ((idx > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            rd_en = r;
            tick();
            cyc++;
            if (r) begin
                exp_rd_data = exp_q[idx];
                check("rd_valid", rd_valid, 1);
                check("rd_data", rd_data, exp_rd_data);
                check("rd_last", rd_last, (idx == DP - 1));
                idx++;
            end else begin
                check("rd_idle_valid", rd_valid, 0);
                check("rd_hold_data", rd_data, exp_rd_data);
                check("rd_idle_last", rd_last, 0);
            end
            check("rd_busy", busy, (idx > 0 && idx < DP));
            check("rd_done", done, (idx == 0));
        end
        arm = 1'b0;
        if (cyc >= 300) check("rd_cycle_budget", cyc, 0);
        // rd_en after the last word, now in IDLE, is ignored
        for (int i = 0; i < 2; i++) begin
            rd_en = 1'b1;
            tick();
            check("post_rd_valid", rd_valid, 0);
            check("post_rd_busy", busy, 0);
            check("post_rd_done", done, 0);
            check("post_rd_data", rd_data, exp_rd_data);
        end
        rd_en = 1'b0;
    endtask

    initial begin
        // power-on reset: low from 2 ns to 14 ns
        #2 reset = 1'b0;
        #6;
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_rd_data", rd_data, 0);
        #6 reset = 1'b1;
        exp_rd_data = '0;
        tick();

        // rd_en / trig in IDLE are ignored
        rd_en = 1'b1; trig = 1'b1; din_valid = 1'b1;
        tick();
        check("idle_rd_valid", rd_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_count", count, 0);
        rd_en = 1'b0; trig = 1'b0; din_valid = 1'b0;

        capture(0, 0, 0);       // ramp 0..15, valid every cycle
        readout(0, 1'b0);       // continuous readout
        capture(0, 2, 3);       // trig without valid, first word 7
        check("first_word", exp_q[0], 7);
        readout(1, 1'b1);       // arm with first rd_en, every third cycle
        capture(1, 0, 0);       // valid every other cycle
        readout(2, 1'b0);
        capture(2, 1, 2);

        // arm alone from FULL restarts a capture with count cleared
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("full_rearm_busy", busy, 1);
        check("full_rearm_done", done, 0);
        check("full_rearm_count", count, 0);
        capture(2, 1, 0);
        readout(2, 1'b1);

        // asynchronous reset in the middle of a capture
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            trig = 1'b1; din_valid = 1'b1; din = DW'($urandom);
            tick();
        end
        trig = 1'b0; din_valid = 1'b0;
        check("mid_count", count, 5);
        #2 reset = 1'b0;
        #1;
        check("midrst_count", count, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rd_data", rd_data, 0);
        exp_rd_data = '0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);

        capture(0, 1, 1);
        readout(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
